acc_instr_queue: RTL

Instruction buffer between the CPU accelerator-issue port and `acc_ctl`. It accepts `acc_instr_t` words from the CPU with a valid/ready handshake, holds up to `DEPTH` of them in order, and presents the head entry to `acc_ctl`. The head entry is retired when the controller signals ready. The block also drives occupancy and idle status, which the CPU uses for back-pressure and fence decisions.

---
 rtl/acc_pkg.sv | 20 ++
 rtl/acc_instr_queue.sv | 85 ++++++++
 2 files changed

// File: rtl/acc_pkg.sv
// Shared accelerator types: instruction word and queue sizing.
package acc_pkg;

    localparam int unsigned ACC_IQ_DEPTH = 4;

    typedef enum logic [1:0] {
        ACC_OP_MAC,
        ACC_OP_LD,
        ACC_OP_ST,
        ACC_OP_CFG
    } acc_op_e;

    typedef struct packed {
        acc_op_e     op;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } acc_instr_t;

endpackage

// File: rtl/acc_instr_queue.sv
// In-order instruction buffer between the CPU issue port and acc_ctl.
// Head entry falls through to the controller; status feeds CPU fencing.
module acc_instr_queue
    import acc_pkg::*;
#(
    parameter int unsigned DEPTH = ACC_IQ_DEPTH,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  acc_instr_t       instr_i,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    output acc_instr_t       acc_instr_o,
    output logic             acc_instr_valid_o,
    input  logic             acc_ready_i,
    input  logic             acc_busy_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             idle_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    acc_instr_t       mem_q [DEPTH];
    acc_instr_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push;
    logic             pop;

    assign full_o            = (cnt_q == CNT_W'(DEPTH));
    assign empty_o           = (cnt_q == '0);
    assign count_o           = cnt_q;
    assign instr_ready_o     = rst_ni & ~full_o & ~flush_i;
    assign acc_instr_valid_o = ~empty_o;
    assign acc_instr_o       = mem_q[rptr_q];
    assign idle_o            = empty_o & ~acc_busy_i;

    assign push = instr_valid_i & instr_ready_o;
    assign pop  = acc_instr_valid_o & acc_ready_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            // flush wins over a same-cycle pop
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + PTR_W'(1);
            if (pop)  rptr_d = rptr_q + PTR_W'(1);
            if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
            if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wptr_q] = instr_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // storage is deliberately left unreset
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule
